// File: rtl/uart_rx_oversampled_if.sv
// Byte stream carrying received UART characters from the receiver to its consumer.
// Ports: data_out (byte, stable while valid), data_valid (held until taken),
//        data_ready (consumer takes data_out when data_valid & data_ready).
interface uart_rx_oversampled_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;

  // Receiver side produces bytes.
  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  // Consumer side accepts bytes.
  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// UART receive engine: 16x oversampled, 3-sample majority vote, 8N1/8E1/8O1 framing.
// Ports: clk, rst (async active-low), rx (serial line, idle high), bus (byte stream,
//        master side), frame_err/parity_err/overrun_err (1-cycle pulses), busy (not IDLE).
module uart_rx_oversampled #(
  parameter int BAUD_DIV   = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  uart_rx_oversampled_if.master bus,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int DIV_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(BAUD_DIV - 1);
  localparam logic [TICK_W-1:0] T_S0     = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] T_S1     = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0] T_DEC    = TICK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [TICK_W-1:0] T_LAST   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic              PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DELIVER,
    S_BREAK
  } state_t;

  state_t state, state_n;

  logic                 rx_meta, rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 smp0, smp1;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_pend;

  logic tick, decide, bit_end, maj, last_bit, start_det, accept;

  // Two-flop synchronizer; idle-high reset value so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick      = (div_cnt == DIV_LAST);
  assign decide    = tick && (tick_cnt == T_DEC);
  assign bit_end   = tick && (tick_cnt == T_LAST);
  // Third vote is rx_s itself on the deciding tick.
  assign maj       = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
  assign last_bit  = (bit_cnt == BIT_LAST);
  assign start_det = (state == S_IDLE) && !rx_s;
  assign accept    = bus.data_valid && bus.data_ready;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (!rx_s) state_n = S_START;
      S_START: begin
        if (decide && maj)  state_n = S_IDLE;   // false start, no flag
        else if (bit_end)   state_n = S_DATA;
      end
      S_DATA: begin
        if (bit_end && last_bit) state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY:  if (bit_end) state_n = S_STOP;
      // Stop bit is judged at mid-bit so the next start edge is never missed.
      S_STOP:    if (decide) state_n = maj ? S_DELIVER : S_BREAK;
      S_DELIVER: state_n = S_IDLE;
      // Hold here while the line is low so a break cannot retrigger a start.
      S_BREAK:   if (rx_s) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt        <= '0;
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      smp0           <= 1'b1;
      smp1           <= 1'b1;
      shreg          <= '0;
      par_pend       <= 1'b0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      frame_err      <= 1'b0;
      parity_err     <= 1'b0;
      overrun_err    <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;

      // Restarting the dividers on the detected edge centres the samples in each bit.
      if (start_det) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
        bit_cnt  <= '0;
        par_pend <= 1'b0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
      end

      if (tick && (tick_cnt == T_S0)) smp0 <= rx_s;
      if (tick && (tick_cnt == T_S1)) smp1 <= rx_s;

      if ((state == S_DATA) && decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
      if ((state == S_DATA) && bit_end) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;

      if ((state == S_PARITY) && decide && (maj != ((^shreg) ^ PAR_ODD))) par_pend <= 1'b1;

      if ((state == S_STOP) && decide && !maj) frame_err <= 1'b1;

      // Handshake clear first; a same-cycle delivery below overrides it.
      if (accept) bus.data_valid <= 1'b0;

      if (state == S_DELIVER) begin
        if (par_pend) begin
          parity_err <= 1'b1;
        end else if (bus.data_valid && !bus.data_ready) begin
          overrun_err <= 1'b1;   // keep the unread byte, drop the new one
        end else begin
          bus.data_out   <= shreg;
          bus.data_valid <= 1'b1;
        end
      end
    end
  end

endmodule
